// File: rtl/graph_pkg.sv
// Shared constants, types and drain FSM encoding for the vid SRAM read-back path.
package graph_pkg;

   localparam int K              = 16;
   localparam int Q              = 16;
   localparam int VID_BW         = 16;
   localparam int VID_ADDR_SPACE = 4;

   localparam int ROW_W  = Q * VID_BW;
   localparam int BANK_W = (K > 1) ? $clog2(K) : 1;
   localparam int NROWS  = 2 ** VID_ADDR_SPACE;

   typedef logic [ROW_W-1:0]          vid_row_t;
   typedef logic [BANK_W-1:0]         bank_idx_t;
   typedef logic [VID_ADDR_SPACE-1:0] vid_addr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } drain_state_t;

   // A pop in the same cycle frees a slot, which is what sustains one row per cycle.
   function automatic logic credit_ok(input logic [1:0] count, input logic inflight,
                                      input logic pop);
      return ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
   endfunction

endpackage

// File: rtl/vid_drain_fifo2.sv
// Two-entry FIFO holding {last, addr, bank, data} rows ahead of the output handshake.
module vid_drain_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] entry_reg [2];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   logic [1:0]   count_reg;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop && (count_reg != 2'd0);
   // Writing into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = push && ((count_reg != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) entry_reg[i] <= '0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) begin
            entry_reg[wr_ptr_reg] <= push_data;
            wr_ptr_reg            <= ~wr_ptr_reg;
         end
         if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head  = entry_reg[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == 2'd2);
   assign empty = (count_reg == 2'd0);

endmodule

// File: rtl/vid_sram_drain.sv
// Sweeps all vid SRAM banks address-major and streams each row out over valid/ready.
// Optional running XOR of accepted rows on port cksum when VID_DRAIN_CKSUM_EN is defined.
import graph_pkg::*;

module vid_sram_drain (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic [VID_ADDR_SPACE-1:0] vid_sram_raddr,
   input  logic [K*ROW_W-1:0]        vid_sram_rdata_all,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ROW_W-1:0]          out_data,
   output logic [BANK_W-1:0]         out_bank,
   output logic [VID_ADDR_SPACE-1:0] out_addr,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done
`ifdef VID_DRAIN_CKSUM_EN
   ,
   output logic [ROW_W-1:0]          cksum
`endif
);

   localparam int        FIFO_W    = 1 + VID_ADDR_SPACE + BANK_W + ROW_W;
   localparam bank_idx_t BANK_LAST = bank_idx_t'(K - 1);
   localparam vid_addr_t ADDR_LAST = '1;

   drain_state_t state_reg, state_next;
   bank_idx_t    bank_cnt_reg;
   vid_addr_t    addr_cnt_reg;

   logic         rd_valid_reg;
   bank_idx_t    rd_bank_reg;
   vid_addr_t    rd_addr_reg;
   logic         rd_last_reg;

   vid_row_t     bank_rows [K];
   logic [FIFO_W-1:0] fifo_head;
   logic [1:0]   fifo_count;
   logic         fifo_full;
   logic         fifo_empty;
   logic         head_last;
   logic         pop;
   logic         issue;
   logic         is_final;

   generate
      for (genvar gi = 0; gi < K; gi++) begin : g_bank
         assign bank_rows[gi] = vid_sram_rdata_all[gi*ROW_W +: ROW_W];
      end
   endgenerate

   assign pop      = out_valid && out_ready;
   assign is_final = (bank_cnt_reg == BANK_LAST) && (addr_cnt_reg == ADDR_LAST);
   assign issue    = (state_reg == ST_RUN) && credit_ok(fifo_count, rd_valid_reg, pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) state_next = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (issue && is_final) state_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            busy = 1'b1;
            // Finish in the cycle the final row leaves, so done follows its acceptance directly.
            if (!rd_valid_reg && (fifo_empty || (!fifo_full && pop))) state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Bank runs fastest; the address holds on the final row instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_cnt_reg <= '0;
         addr_cnt_reg <= '0;
      end else if (state_reg == ST_IDLE && start) begin
         bank_cnt_reg <= '0;
         addr_cnt_reg <= '0;
      end else if (issue) begin
         if (bank_cnt_reg == BANK_LAST) begin
            bank_cnt_reg <= '0;
            if (!is_final) addr_cnt_reg <= addr_cnt_reg + 1'b1;
         end else begin
            bank_cnt_reg <= bank_cnt_reg + 1'b1;
         end
      end
   end

   // Tags travel one cycle behind the address to line up with the SRAM read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_reg <= 1'b0;
         rd_bank_reg  <= '0;
         rd_addr_reg  <= '0;
         rd_last_reg  <= 1'b0;
      end else begin
         rd_valid_reg <= issue;
         if (issue) begin
            rd_bank_reg <= bank_cnt_reg;
            rd_addr_reg <= addr_cnt_reg;
            rd_last_reg <= is_final;
         end
      end
   end

   vid_drain_fifo2 #(
      .W (FIFO_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_valid_reg),
      .push_data ({rd_last_reg, rd_addr_reg, rd_bank_reg, bank_rows[rd_bank_reg]}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign {head_last, out_addr, out_bank, out_data} = fifo_head;
   assign out_valid      = !fifo_empty;
   assign out_last       = head_last && out_valid;
   assign vid_sram_raddr = addr_cnt_reg;

`ifdef VID_DRAIN_CKSUM_EN
   logic [ROW_W-1:0] cksum_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            cksum_reg <= '0;
      else if (state_reg == ST_IDLE && start) cksum_reg <= '0;
      else if (pop)                          cksum_reg <= cksum_reg ^ out_data;
   end

   assign cksum = cksum_reg;
`endif

endmodule

// File: tb/tb_vid_sram_drain.sv
// Bench for vid_sram_drain: SRAM model, row-order reference model and scenario tasks.
import graph_pkg::*;

module tb_vid_sram_drain;

   typedef struct packed {
      logic [ROW_W-1:0]          data;
      logic [BANK_W-1:0]         bank;
      logic [VID_ADDR_SPACE-1:0] addr;
      logic                      last;
   } row_t;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      start;
   logic [VID_ADDR_SPACE-1:0] vid_sram_raddr;
   logic [K*ROW_W-1:0]        vid_sram_rdata_all;
   logic                      out_valid;
   logic                      out_ready;
   logic [ROW_W-1:0]          out_data;
   logic [BANK_W-1:0]         out_bank;
   logic [VID_ADDR_SPACE-1:0] out_addr;
   logic                      out_last;
   logic                      busy;
   logic                      done;
`ifdef VID_DRAIN_CKSUM_EN
   logic [ROW_W-1:0]          cksum;
`endif

   vid_sram_drain dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .vid_sram_raddr     (vid_sram_raddr),
      .vid_sram_rdata_all (vid_sram_rdata_all),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_data           (out_data),
      .out_bank           (out_bank),
      .out_addr           (out_addr),
      .out_last           (out_last),
      .busy               (busy),
      .done               (done)
`ifdef VID_DRAIN_CKSUM_EN
      ,
      .cksum              (cksum)
`endif
   );

   always #5 clk = ~clk;

   logic [ROW_W-1:0] mem [K][NROWS];

   // Registered-read SRAM: data for raddr appears one cycle later.
   always @(posedge clk) begin
      for (int b = 0; b < K; b++) vid_sram_rdata_all[b*ROW_W +: ROW_W] <= mem[b][vid_sram_raddr];
   end

   int   errors = 0;
   int   checks = 0;
   row_t exp_q[$];
   row_t got_q[$];
   int   first_valid, last_accept, done_cycle, done_pulses, stall_bad, raddr_bad;
   logic busy_end;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic fill_pattern();
      logic [VID_BW-1:0] v;
      for (int b = 0; b < K; b++)
         for (int a = 0; a < NROWS; a++) begin
            v = VID_BW'((b << 8) | a);
            mem[b][a] = {Q{v}};
         end
   endtask

   task automatic fill_random();
      for (int b = 0; b < K; b++)
         for (int a = 0; a < NROWS; a++)
            for (int w = 0; w < ROW_W / 32; w++) mem[b][a][w*32 +: 32] = $urandom;
   endtask

   // Reference: every address in turn, every bank within it, last flag on the very final row.
   task automatic build_expected();
      row_t r;
      exp_q.delete();
      for (int a = 0; a < NROWS; a++)
         for (int b = 0; b < K; b++) begin
            r.data = mem[b][a];
            r.bank = BANK_W'(b);
            r.addr = VID_ADDR_SPACE'(a);
            r.last = (a == NROWS - 1) && (b == K - 1);
            exp_q.push_back(r);
         end
   endtask

   function automatic int row_mismatches();
      int m = 0;
      int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) m++;
      m += (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
      return m;
   endfunction

   // Consumes rows until done (plus a short tail); mode 0 ready=1, 1 ready 1,0,0,1, else random.
   task automatic capture(input int mode, input int restart_a, input int restart_b, input int budget);
      row_t cur, prev;
      logic prev_stall = 1'b0;
      int   cyc = 0;
      got_q.delete();
      first_valid = -1; last_accept = -1; done_cycle = -1;
      done_pulses = 0;  stall_bad = 0;    raddr_bad = 0;
      prev = '0;
      while (cyc < budget && (done_cycle < 0 || cyc < done_cycle + 4)) begin
         start = (cyc == restart_a) || (cyc == restart_b);
         if (mode == 0)      out_ready = 1'b1;
         else if (mode == 1) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         else                out_ready = 1'($urandom_range(0, 1));
         cur = {out_data, out_bank, out_addr, out_last};
         if (prev_stall && (!out_valid || cur !== prev)) stall_bad++;
         if (int'(vid_sram_raddr) * K > got_q.size() + 2) raddr_bad++;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (done) begin
            done_pulses++;
            if (done_cycle < 0) done_cycle = cyc;
         end
         if (out_valid && out_ready) begin
            got_q.push_back(cur);
            last_accept = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev       = cur;
         tick();
         cyc++;
      end
      start    = 1'b0;
      busy_end = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      tick(); tick();
      checks++; if (vid_sram_raddr !== '0) begin errors++; $display("FAIL reset_raddr: got %0d expected 0", vid_sram_raddr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
      checks++; if (out_bank !== '0) begin errors++; $display("FAIL reset_bank: got %0d expected 0", out_bank); end
      checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", out_addr); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b expected 0", out_last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
`ifdef VID_DRAIN_CKSUM_EN
      checks++; if (cksum !== '0) begin errors++; $display("FAIL reset_cksum: got %h expected 0", cksum); end
`endif
      rst_n = 1'b1;
      tick(); tick();
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%0b valid=%0b expected 0 0", busy, out_valid); end
      $display("test_reset: done");
   endtask

   task automatic test_stream();
      fill_pattern();
      build_expected();
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy: got %0b expected 1", busy); end
      capture(0, -1, -1, 600);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stream_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      checks++; if (row_mismatches() != 0) begin errors++; $display("FAIL stream_rows: got %0d bad rows expected 0", row_mismatches()); end
      checks++; if (first_valid != 2) begin errors++; $display("FAIL stream_latency: got %0d expected 2", first_valid); end
      checks++; if (last_accept != first_valid + 255) begin errors++; $display("FAIL stream_throughput: got %0d expected %0d", last_accept, first_valid + 255); end
      checks++; if (done_cycle != last_accept + 1) begin errors++; $display("FAIL stream_done_time: got %0d expected %0d", done_cycle, last_accept + 1); end
      checks++; if (done_pulses != 1) begin errors++; $display("FAIL stream_done_pulses: got %0d expected 1", done_pulses); end
      checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL stream_busy_end: got %0b expected 0", busy_end); end
      $display("test_stream: rows=%0d first_valid=%0d done_cycle=%0d", got_q.size(), first_valid, done_cycle);
   endtask

   task automatic test_backpressure(input int mode);
      fill_random();
      build_expected();
      pulse_start();
      capture(mode, -1, -1, 3000);
      checks++; if (row_mismatches() != 0) begin errors++; $display("FAIL bp%0d_rows: got %0d bad rows expected 0", mode, row_mismatches()); end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp%0d_stable: got %0d changes expected 0", mode, stall_bad); end
      checks++; if (raddr_bad != 0) begin errors++; $display("FAIL bp%0d_credit: got %0d early reads expected 0", mode, raddr_bad); end
      checks++; if (done_cycle != last_accept + 1 || done_pulses != 1) begin errors++; $display("FAIL bp%0d_done: got cycle %0d pulses %0d expected %0d 1", mode, done_cycle, done_pulses, last_accept + 1); end
      $display("test_backpressure mode=%0d: rows=%0d done_cycle=%0d", mode, got_q.size(), done_cycle);
   endtask

   task automatic test_stall20();
      row_t cur;
      int   moved = 0;
      fill_random();
      build_expected();
      out_ready = 1'b0;
      pulse_start();
      for (int c = 0; c < 20; c++) begin
         cur = {out_data, out_bank, out_addr, out_last};
         if (c >= 2 && (!out_valid || cur !== exp_q[0])) moved++;
         tick();
      end
      checks++; if (moved != 0) begin errors++; $display("FAIL stall_head: got %0d bad cycles expected 0", moved); end
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL stall_valid: valid=%0b busy=%0b expected 1 1", out_valid, busy); end
      capture(0, -1, -1, 600);
      checks++; if (row_mismatches() != 0) begin errors++; $display("FAIL stall_rows: got %0d bad rows expected 0", row_mismatches()); end
      checks++; if (last_accept != 255) begin errors++; $display("FAIL stall_release: got %0d expected 255", last_accept); end
      $display("test_stall20: rows=%0d last_accept=%0d", got_q.size(), last_accept);
   endtask

   task automatic test_reset_mid();
      int   n = 0;
      int   cyc = 0;
      int   stray_done = 0;
      logic hit = 1'b0;
      fill_random();
      build_expected();
      pulse_start();
      while (cyc < 2000 && !hit) begin
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            if (n == 100) hit = 1'b1;
            n++;
         end
         tick();
         cyc++;
      end
      checks++; if (!hit) begin errors++; $display("FAIL midrst_reach: got %0d rows expected 101", n); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: valid=%0b busy=%0b done=%0b expected 0 0 0", out_valid, busy, done); end
      checks++; if (vid_sram_raddr !== '0 || out_data !== '0 || out_bank !== '0 || out_addr !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL midrst_data: raddr=%0d bank=%0d addr=%0d last=%0b expected 0", vid_sram_raddr, out_bank, out_addr, out_last); end
      tick(); tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (done) stray_done++;
         tick();
      end
      checks++; if (stray_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", stray_done); end
      pulse_start();
      capture(2, -1, -1, 3000);
      checks++; if (row_mismatches() != 0) begin errors++; $display("FAIL midrst_restart: got %0d bad rows expected 0", row_mismatches()); end
      $display("test_reset_mid: rows after restart=%0d", got_q.size());
   endtask

   task automatic test_start_ignored();
      fill_random();
      build_expected();
      pulse_start();
      capture(0, 50, 257, 800);
      checks++; if (got_q.size() != 256) begin errors++; $display("FAIL ignore_count: got %0d expected 256", got_q.size()); end
      checks++; if (row_mismatches() != 0) begin errors++; $display("FAIL ignore_rows: got %0d bad rows expected 0", row_mismatches()); end
      checks++; if (done_pulses != 1 || busy_end !== 1'b0) begin errors++; $display("FAIL ignore_end: pulses=%0d busy=%0b expected 1 0", done_pulses, busy_end); end
      $display("test_start_ignored: rows=%0d pulses=%0d", got_q.size(), done_pulses);
   endtask

`ifdef VID_DRAIN_CKSUM_EN
   task automatic test_cksum();
      logic [ROW_W-1:0] x = '0;
      fill_pattern();
      build_expected();
      foreach (exp_q[i]) x ^= exp_q[i].data;
      pulse_start();
      capture(2, -1, -1, 3000);
      checks++; if (cksum !== x) begin errors++; $display("FAIL cksum_value: got %h expected %h", cksum, x); end
      pulse_start();
      checks++; if (cksum !== '0) begin errors++; $display("FAIL cksum_clear: got %h expected 0", cksum); end
      capture(0, -1, -1, 600);
      checks++; if (cksum !== x) begin errors++; $display("FAIL cksum_repeat: got %h expected %h", cksum, x); end
      $display("test_cksum: cksum=%h", cksum);
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure(1);
      test_backpressure(2);
      test_stall20();
      test_reset_mid();
      test_start_ignored();
`ifdef VID_DRAIN_CKSUM_EN
      test_cksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vid_sram_drain.md
Name: vid_sram_drain

Overview:
- Downstream of master_top; runs after the master asserts finish.
- Sweeps all K vid SRAM banks through the shared read address and streams each Q*VID_BW-bit row out over a valid/ready interface, tagged with its bank and address.
- Provides the single read-back path for final vertex-ID partitions: 256 rows with the defaults.

Parameters:
- K, 16, number of vid SRAM banks
- Q, 16, VIDs per SRAM row
- VID_BW, 16, bits per VID
- VID_ADDR_SPACE, 4, SRAM address width; rows per bank = 2**VID_ADDR_SPACE

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a drain (tied to master finish)
- vid_sram_raddr  out  VID_ADDR_SPACE  shared read address to all banks
- vid_sram_rdata_all  in  K*Q*VID_BW  concatenated bank read data; bank b occupies bits [(b+1)*Q*VID_BW-1 : b*Q*VID_BW]
- out_valid  out  1  out_data holds a row
- out_ready  in  1  consumer accepts the row when out_valid && out_ready
- out_data  out  Q*VID_BW  row data
- out_bank  out  log2(K)  source bank of the row
- out_addr  out  VID_ADDR_SPACE  source address of the row
- out_last  out  1  high on the final row (bank K-1, last address)
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset values: vid_sram_raddr=0, out_valid=0, out_data=0, out_bank=0, out_addr=0, out_last=0, busy=0, done=0. FSM returns to IDLE. FIFO is emptied.
- Reset asserted mid-drain abandons the drain immediately. No done pulse is produced.
- SRAM timing: rdata is valid one cycle after raddr is presented. The bank select for that data is pipelined alongside it by one cycle.
- Order: address-major, bank-minor. Sequence is (a0,b0),(a0,b1)..(a0,bK-1),(a1,b0)..; 2**VID_ADDR_SPACE*K rows total.
- raddr holds at the current address while the bank index runs 0..K-1, then increments.
- FSM states:
  - IDLE: start -> RUN. Counters cleared, busy=1.
  - RUN: issues one read per cycle only when the credit check passes (see Buffering). After the final issue -> FLUSH.
  - FLUSH: waits for the FIFO to empty and the last row to be accepted -> DONE.
  - DONE: pulses done for one cycle, busy=0 -> IDLE.
  - start is ignored outside IDLE.
- Buffering: a 2-entry output FIFO is fed from the rdata pipeline stage.
  - Credit = 2 - FIFO occupancy - reads in flight.
  - Issue only when credit > 0.
  - out_valid is never dropped without a handshake. out_data, out_bank, out_addr and out_last are stable while out_valid && !out_ready.
- With out_ready held at 1, throughput is one row per cycle. Latency from start to the first out_valid is 2 cycles.
- Simultaneous push and pop on a full FIFO is legal, and occupancy is unchanged. Push into a full FIFO without a pop cannot happen, because the credit check prevents it.
- Counters: bank index wraps K-1 -> 0 and carries into the address. The address counter does not wrap past the last row; the end of the sweep terminates RUN.

Optional Feature:
- Macro: VID_DRAIN_CKSUM_EN.
- Defined:
  - Adds output cksum [Q*VID_BW-1:0], which is the running XOR of every accepted out_data.
  - cksum clears on start and holds its value after done until the next start.
  - Reset value is 0.
- Undefined: no cksum port and no checksum logic.

Decomposition:
- Package graph_pkg: K, Q, VID_BW and VID_ADDR_SPACE constants; typedefs vid_row_t (Q*VID_BW bits), bank_idx_t and vid_addr_t; the drain FSM state enum.
- One sub-module: vid_drain_fifo2, a 2-entry FIFO carrying {data, bank, addr, last}.
  - Outputs: count, full, empty.
  - Asynchronous active-low reset.

Test Plan:
- Bank b row a preloaded with 16'h{b,a} replicated; out_ready=1; pulse start -> 256 rows in consecutive cycles, starting 2 cycles after start, in order (a0,b0)..(a15,b15). out_last only on row 255. done pulses on the cycle after row 255 is accepted.
- out_ready toggles 1,0,0,1 repeatedly -> no row lost or duplicated; payload stable while stalled; raddr never advances while credit = 0.
- out_ready=0 for 20 cycles right after start -> exactly 2 rows buffered, out_valid high, no further reads; on release the rows drain in order.
- rst_n driven low when row 100 is accepted -> all outputs at reset values asynchronously and no done pulse; a new start restarts from (a0,b0).
- start pulsed again during RUN and during FLUSH -> ignored; row count stays 256.
- With VID_DRAIN_CKSUM_EN and the preload from the first scenario -> cksum after done equals the XOR of all 256 rows computed by the bench; a second start clears cksum to 0.
